// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the multiply sequencer and the ALU control decoder.
package mul_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int SHAMT_W = 5;
  localparam int CNT_W = 5;

  // ALU operation codes, fixed by the ALU
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b0001;
  localparam logic [3:0] ALU_LUI = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b1000;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ADD   = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier controller that borrows the shared ALU for every
// add and operand shift, producing the low 32 bits of op_a * op_b.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1,
  parameter int ALU_OP_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [SHAMT_W-1:0]  alu_shamt,
  input  logic [DATA_W-1:0]   alu_result
);

  seq_state_e        state;
  seq_state_e        state_nxt;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mplier_shr;

  // The multiplier shifts internally; the ALU is only needed for the wide add
  // and for doubling the multiplicand.
  assign mplier_shr = mplier >> 1;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and ALU drive for the current step
  always_comb begin
    state_nxt     = state;
    alu_operation = ALU_OP_W'(ALU_ADD);
    alu_a         = '0;
    alu_b         = '0;
    alu_shamt     = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // A zero multiplier needs no iterations at all when early exit is on
          if (EARLY_EXIT && (op_b == '0)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ADD;
          end
        end
      end
      ST_ADD: begin
        alu_a     = prod;
        alu_b     = mplier[0] ? mcand : '0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        alu_operation = ALU_OP_W'(ALU_SLL);
        alu_a         = mcand;
        alu_shamt     = SHAMT_W'(1);
        // Stop after the 32nd bit, or as soon as no set multiplier bits remain
        if ((cnt == CNT_W'(31)) || (EARLY_EXIT && (mplier_shr == '0))) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_ADD;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Working registers: operand capture, accumulate, multiplicand doubling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            prod   <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= '0;
          end
        end
        ST_ADD: begin
          prod <= alu_result;
        end
        ST_SHIFT: begin
          mcand  <= alu_result;
          mplier <= mplier_shr;
          cnt    <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result capture on entry to DONE so it is visible alongside the done pulse;
  // a zero-multiplier fast path comes straight from IDLE with a zero product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (state_nxt == ST_DONE) begin
      result <= (state == ST_IDLE) ? '0 : prod;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: two instances (early exit on and off), each wired
// to a behavioural model of the shared ALU.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;

  logic        busy0, done0, busy1, done1;
  logic [31:0] result0, result1;
  logic [3:0]  aop0, aop1;
  logic [31:0] aa0, ab0, aa1, ab1, ares0, ares1;
  logic [4:0]  ash0, ash1;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: return a << sh;
      4'b0001: return a >> sh;
      4'b0010: return {b[15:0], 16'h0000};
      4'b0011: return a + b;
      4'b0100: return a - b;
      4'b0101: return a & b;
      4'b0111: return ~(a | b);
      4'b1000: return a | b;
      default: return 32'h0;
    endcase
  endfunction

  always_comb ares0 = alu_model(aop0, aa0, ab0, ash0);
  always_comb ares1 = alu_model(aop1, aa1, ab1, ash1);

  mul_sequencer #(.EARLY_EXIT(1'b1), .ALU_OP_W(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(op_a), .op_b(op_b),
    .busy(busy0), .done(done0), .result(result0),
    .alu_operation(aop0), .alu_a(aa0), .alu_b(ab0), .alu_shamt(ash0),
    .alu_result(ares0)
  );

  mul_sequencer #(.EARLY_EXIT(1'b0), .ALU_OP_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a), .op_b(op_b),
    .busy(busy1), .done(done1), .result(result1),
    .alu_operation(aop1), .alu_a(aa1), .alu_b(ab1), .alu_shamt(ash1),
    .alu_result(ares1)
  );

  // Reference: product modulo 2^32 and cycle count from the multiplier's top set bit
  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input bit ee);
    int n;
    if (!ee) return 65;
    if (b == 0) return 1;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return 2 * n + 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one multiply on instance sel; optionally pulse a stray start at cycle inject
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int el, input int inject, input string nm);
    int   lat, bcnt, terr;
    logic got;
    op_a = a;
    op_b = b;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 0; bcnt = 0; terr = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if ((sel == 0) ? busy0 : busy1) bcnt++;
      if (sel == 1 && lat <= 64) begin
        if (aop1 != ((lat % 2 == 1) ? 4'b0011 : 4'b0000)) terr++;
      end
      if (inject != 0 && lat == inject) begin
        start0 = 1'b1; op_a = 32'd9; op_b = 32'd9;
      end else if (inject != 0 && lat == inject + 1) begin
        start0 = 1'b0;
      end
      got = (sel == 0) ? done0 : done1;
    end
    start0 = 1'b0;
    check({nm, " latency"}, lat, el);
    check({nm, " result"}, (sel == 0) ? result0 : result1, er);
    check({nm, " busy cycles"}, bcnt, el);
    if (sel == 1) check({nm, " alu trace"}, terr, 0);
    @(negedge clk);
    check({nm, " idle after done"}, {30'b0, (sel == 0) ? busy0 : busy1, (sel == 0) ? done0 : done1}, 32'h0);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    int          el;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int dcnt;
    logic [31:0] ra, rb;

    vecs.push_back('{0, 32'd6,        32'd7,        32'd42,       7,  "6x7"});
    vecs.push_back('{0, 32'h1234,     32'd0,        32'd0,        1,  "x0 early"});
    vecs.push_back('{0, 32'd0,        32'd5,        32'd0,        7,  "0x5"});
    vecs.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        65, "ones sq"});
    vecs.push_back('{0, 32'h80000000, 32'd2,        32'h0,        5,  "wrap"});
    vecs.push_back('{0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 7,  "signed"});
    vecs.push_back('{1, 32'd3,        32'd1,        32'd3,        65, "full 3x1"});
    vecs.push_back('{1, 32'h12345678, 32'd0,        32'd0,        65, "full x0"});

    // Reset state, asserted from time zero
    #3;
    check("reset busy", {31'b0, busy0}, 32'h0);
    check("reset done", {31'b0, done0}, 32'h0);
    check("reset result", result0, 32'h0);
    check("idle alu op", {28'b0, aop0}, 32'h3);
    check("idle alu operands", aa0 | ab0 | {27'b0, ash0}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].el, 0, vecs[i].nm);

    // Stray start mid-operation is ignored; next start right after DONE is taken
    run_op(0, 32'd5, 32'd5, 32'd25, 7, 2, "ignore start");
    run_op(0, 32'd9, 32'd9, 32'd81, 9, 0, "back to back");

    // Asynchronous reset during a SHIFT step of 100*100
    op_a = 32'd100; op_b = 32'd100;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset in shift", {31'b0, busy0}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async reset busy", {31'b0, busy0}, 32'h0);
    check("async reset done", {31'b0, done0}, 32'h0);
    check("async reset result", result0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0 || busy0) dcnt++;
    end
    check("no done after abort", dcnt, 0);
    run_op(0, 32'd10, 32'd10, 32'd100, 9, 0, "after reset");

    // Randomised operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(0, ra, rb, ref_prod(ra, rb), ref_lat(rb, 1'b1), 0, "rand ee");
    end
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(1, ra, rb, ref_prod(ra, rb), ref_lat(rb, 1'b0), 0, "rand full");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
